// File: rtl/axis_step_driver_pkg.sv
// Shared types and default timing constants for the two-axis step driver.
package axis_step_driver_pkg;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_SETUP = 2'd1,
    CH_HIGH  = 2'd2,
    CH_LOW   = 2'd3
  } ch_state_e;

  localparam int DEF_PULSE_W    = 4;
  localparam int DEF_DIR_SETUP  = 2;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/axis_step_channel.sv
// One axis: request edge detect, pending-direction queue, pulse FSM, position.
//
// state    | meaning
// CH_IDLE  | nothing in flight; pops the queue when non-empty
// CH_SETUP | direction just changed; holding dir stable before step rises
// CH_HIGH  | step output high for PULSE_W cycles
// CH_LOW   | step output low for PULSE_W cycles; pops directly if more queued
module axis_step_channel
  import axis_step_driver_pkg::*;
#(
  parameter int PULSE_W    = DEF_PULSE_W,
  parameter int DIR_SETUP  = DEF_DIR_SETUP,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_p_i,
  input  logic        req_m_i,
  output logic        step_o,
  output logic        dir_o,
  output logic [31:0] pos_o,
  output logic        busy_o,
  output logic        ovf_o,
  output logic        err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                  req_p_q, req_m_q;
  logic [FIFO_DEPTH-1:0] fifo_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  ch_state_e             state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  step_q, step_d;
  logic                  dir_q, dir_d;
  logic [31:0]           pos_q, pos_d;
  logic                  ovf_q, err_q;

  logic rise_p, rise_m, push, accept, pop, launch, empty, full, head_dir;

  assign rise_p   = req_p_i & ~req_p_q;
  assign rise_m   = req_m_i & ~req_m_q;
  assign push     = rise_p ^ rise_m;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign head_dir = fifo_q[rd_ptr_q];
  // A full queue still takes a push when the same edge frees a slot.
  assign accept   = push & (~full | pop);

  // Queue occupancy next value.
  always_comb begin
    count_d = count_q;
    if (accept && !pop)      count_d = count_q + CNT_W'(1);
    else if (!accept && pop) count_d = count_q - CNT_W'(1);
  end

  // Channel FSM next state, step/dir/position and pop decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    launch  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      CH_IDLE: launch = ~empty;
      CH_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = CH_HIGH;
          step_d  = 1'b1;
          cnt_d   = 8'(PULSE_W - 1);
          pos_d   = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CH_HIGH: begin
        if (cnt_q == 8'd0) begin
          state_d = CH_LOW;
          step_d  = 1'b0;
          cnt_d   = 8'(PULSE_W - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CH_LOW: begin
        if (cnt_q == 8'd0) begin
          if (empty) state_d = CH_IDLE;
          else       launch  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = CH_IDLE;
    endcase
    // Same direction steps immediately; a reversal first waits out the setup time.
    if (launch) begin
      pop = 1'b1;
      if (head_dir == dir_q) begin
        state_d = CH_HIGH;
        step_d  = 1'b1;
        cnt_d   = 8'(PULSE_W - 1);
        pos_d   = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
      end else begin
        state_d = CH_SETUP;
        step_d  = 1'b0;
        dir_d   = head_dir;
        cnt_d   = 8'(DIR_SETUP - 1);
      end
    end
  end

  // Request sampling, queue storage and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_p_q  <= 1'b0;
      req_m_q  <= 1'b0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      req_p_q <= req_p_i;
      req_m_q <= req_m_i;
      if (accept) begin
        fifo_q[wr_ptr_q] <= rise_p;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (push && !accept)    ovf_q <= 1'b1;
      if (rise_p && rise_m)   err_q <= 1'b1;
    end
  end

  // FSM state, step output, direction and position registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CH_IDLE;
      cnt_q   <= 8'd0;
      step_q  <= 1'b0;
      dir_q   <= 1'b1;
      pos_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
    end
  end

  assign step_o = step_q;
  assign dir_o  = dir_q;
  assign pos_o  = pos_q;
  assign busy_o = ~empty | (state_q != CH_IDLE);
  assign ovf_o  = ovf_q;
  assign err_o  = err_q;

endmodule

// File: rtl/axis_step_driver.sv
// Two-axis step/direction driver: independent X/Y channels plus move-level busy/done.
module axis_step_driver
  import axis_step_driver_pkg::*;
#(
  parameter int PULSE_W    = DEF_PULSE_W,
  parameter int DIR_SETUP  = DEF_DIR_SETUP,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ax,
  input  logic        fax,
  input  logic        ay,
  input  logic        fay,
  input  logic        start,
  output logic        step_x,
  output logic        step_y,
  output logic        dir_x,
  output logic        dir_y,
  output logic [31:0] pos_x,
  output logic [31:0] pos_y,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        err
);

  logic busy_x, busy_y, ovf_x, ovf_y, err_x, err_y;
  logic busy_q;

  axis_step_channel #(
    .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_ch_x (
    .clk(clk), .reset(reset), .req_p_i(ax), .req_m_i(fax),
    .step_o(step_x), .dir_o(dir_x), .pos_o(pos_x),
    .busy_o(busy_x), .ovf_o(ovf_x), .err_o(err_x)
  );

  axis_step_channel #(
    .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_ch_y (
    .clk(clk), .reset(reset), .req_p_i(ay), .req_m_i(fay),
    .step_o(step_y), .dir_o(dir_y), .pos_o(pos_y),
    .busy_o(busy_y), .ovf_o(ovf_y), .err_o(err_y)
  );

  // start is a raw input, so busy is masked while reset is held.
  assign busy = ~reset & (start | busy_x | busy_y);
  assign ovf  = ovf_x | ovf_y;
  assign err  = err_x | err_y;

  // Remember last-cycle busy so the falling edge can be flagged once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= 1'b0;
    else       busy_q <= busy;
  end

  assign done = busy_q & ~busy;

endmodule

// File: tb/tb_axis_step_driver.sv
// Directed bench for axis_step_driver with default parameters.
module tb_axis_step_driver;

  logic        clk = 1'b0;
  logic        reset, ax, fax, ay, fay, start;
  logic        step_x, step_y, dir_x, dir_y, busy, done, ovf, err;
  logic [31:0] pos_x, pos_y;

  int total = 0;
  int bad   = 0;

  axis_step_driver dut (
    .clk(clk), .reset(reset), .ax(ax), .fax(fax), .ay(ay), .fay(fay),
    .start(start), .step_x(step_x), .step_y(step_y), .dir_x(dir_x),
    .dir_y(dir_y), .pos_x(pos_x), .pos_y(pos_y), .busy(busy),
    .done(done), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ax = 0; fax = 0; ay = 0; fay = 0; start = 0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  int rises;
  logic prev_x, seen_x;

  initial begin
    reset = 1'b1;
    ax = 0; fax = 0; ay = 0; fay = 0; start = 0;
    do_reset();
    reset = 1'b1;
    #1;
    chk("rst_step_x", step_x, 0);
    chk("rst_step_y", step_y, 0);
    chk("rst_dir_x", dir_x, 1);
    chk("rst_dir_y", dir_y, 1);
    chk("rst_pos_x", pos_x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {30'd0, ovf, err}, 0);
    reset = 1'b0;

    // Single +X step
    do_reset();
    ax = 1; start = 1;
    cyc();
    ax = 0;
    chk("px_step_before", step_x, 0);
    cyc();
    chk("px_step_rise", step_x, 1);
    chk("px_pos", pos_x, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("px_step_high", step_x, 1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("px_step_low", step_x, 0);
    end
    cyc();
    chk("px_dir", dir_x, 1);
    chk("px_busy_start", busy, 1);
    chk("px_done_early", done, 0);
    start = 0;
    #1;
    chk("px_busy_fall", busy, 0);
    chk("px_done_pulse", done, 1);
    cyc();
    chk("px_done_once", done, 0);
    chk("px_pos_final", pos_x, 1);

    // Single -X step with direction setup
    do_reset();
    fax = 1;
    cyc();
    fax = 0;
    cyc();
    chk("mx_dir_pop", dir_x, 0);
    chk("mx_step_setup0", step_x, 0);
    cyc();
    chk("mx_step_setup1", step_x, 0);
    cyc();
    chk("mx_step_rise", step_x, 1);
    chk("mx_pos", pos_x, 32'hFFFF_FFFF);

    // Overflow: 10 requests every 3 cycles, 2 dropped
    do_reset();
    start = 1;
    for (int i = 0; i < 10; i++) begin
      ax = 1;
      cyc();
      ax = 0;
      cyc();
      cyc();
    end
    start = 0;
    for (int k = 0; k < 200 && busy; k++) cyc();
    chk("ovf_drain", busy, 0);
    chk("ovf_flag", ovf, 1);
    chk("ovf_pos", pos_x, 8);
    chk("ovf_err", err, 0);

    // Simultaneous +X/-X plus a Y request
    do_reset();
    ax = 1; fax = 1; ay = 1;
    cyc();
    ax = 0; fax = 0; ay = 0;
    chk("err_flag", err, 1);
    seen_x = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (step_x) seen_x = 1;
    end
    chk("err_no_step_x", seen_x, 0);
    chk("err_pos_x", pos_x, 0);
    chk("err_pos_y", pos_y, 1);
    chk("err_ovf", ovf, 0);

    // Held request produces a single step
    do_reset();
    ax = 1;
    rises = 0;
    prev_x = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) ax = 0;
      cyc();
      if (step_x && !prev_x) rises++;
      prev_x = step_x;
    end
    chk("held_rises", rises, 1);
    chk("held_pos", pos_x, 1);

    // Reset during HIGH
    do_reset();
    ax = 1;
    cyc();
    ax = 0;
    cyc();
    cyc();
    chk("mid_step_high", step_x, 1);
    reset = 1;
    #1;
    chk("mid_step_trunc", step_x, 0);
    chk("mid_pos_clr", pos_x, 0);
    cyc();
    reset = 0;
    ay = 1;
    cyc();
    ay = 0;
    for (int i = 0; i < 12; i++) cyc();
    chk("mid_pos_y", pos_y, 1);
    chk("mid_pos_x", pos_x, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_step_driver.md
AXIS_STEP_DRIVER -- requirements
Module: axis_step_driver

Interface
REQ-001 Parameter PULSE_W, default 4, clock cycles that step_x/step_y are held high and then low per emitted step (range 1..255).
REQ-002 Parameter DIR_SETUP, default 2, clock cycles dir_x/dir_y are stable before step rises after a direction change (range 1..255).
REQ-003 Parameter FIFO_DEPTH, default 4, per-axis pending-step queue depth (power of two, 2..16).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ax / fax  input  1 each  +X / -X step request pulses from the interpolator.
REQ-007 ay / fay  input  1 each  +Y / -Y step request pulses from the interpolator.
REQ-008 start  input  1  interpolator active (high while interpolation runs).
REQ-009 step_x, step_y  output  1 each  step pulses to the axis drives.
REQ-010 dir_x, dir_y  output  1 each  axis direction, 1 = positive.
REQ-011 pos_x, pos_y  output  32 each  signed two's-complement emitted-step position.
REQ-012 busy  output  1  start high, or any queue non-empty, or any channel not IDLE.
REQ-013 done  output  1  one-cycle pulse at end of move.
REQ-014 ovf  output  1  sticky: a request was dropped because its queue was full.
REQ-015 err  output  1  sticky: + and - requests rose in the same cycle on one axis.

Function
REQ-016 Each request input is registered; a request is a 0->1 transition between consecutive clk samples; a level held high produces exactly one request.
REQ-017 A request edge sampled at edge N is pushed (direction bit) into its axis queue at edge N; visible to the channel FSM from edge N+1 (no bypass).
REQ-018 Same-axis +/- edges in the same cycle: both discarded, err set at that edge; the other axis is unaffected.
REQ-019 Queue full with push and no pop: request dropped, ovf set; full with simultaneous push and pop: push accepted, count unchanged.
REQ-020 Channel FSM states: IDLE, SETUP, HIGH, LOW.
REQ-021 IDLE, queue non-empty: pop; if popped dir equals current dir -> HIGH, step rises at this edge; else dir updates at this edge -> SETUP.
REQ-022 SETUP: count DIR_SETUP cycles, then -> HIGH with step rising at edge N+1+DIR_SETUP (N+1 = pop edge).
REQ-023 HIGH: step held high PULSE_W cycles -> LOW; LOW: step low PULSE_W cycles -> IDLE.
REQ-024 Minimum step period 2*PULSE_W cycles back-to-back in the same direction; no extra IDLE cycle is inserted when the queue stays non-empty (LOW exit pops directly, applying REQ-021 decision).
REQ-025 pos increments (dir=1) or decrements (dir=0) by 1 at the edge step rises; wraps modulo 2^32 with no flag.
REQ-026 dir changes only on a pop edge, never during HIGH or LOW.
REQ-027 done pulses for one cycle at the first edge where busy would go 1->0; not asserted again until busy has been high again.
REQ-028 X and Y channels are fully independent; simultaneous steps on both axes are permitted.

Reset
REQ-029 reset asserted: step_x=step_y=0, dir_x=dir_y=1, pos_x=pos_y=0, busy=0, done=0, ovf=0, err=0, queues emptied, FSMs IDLE, request registers 0.
REQ-030 Reset mid-pulse truncates step immediately (asynchronous); pending requests lost.
REQ-031 ovf and err cleared only by reset.

Structure
REQ-032 Shared package holds the channel state enumeration and the default PULSE_W, DIR_SETUP, FIFO_DEPTH constants.
REQ-033 One sub-module axis_step_channel (edge detect, queue, FSM, position counter) instantiated for X and Y; top holds busy/done logic and flag ORs.

Verification
REQ-034 Single ax pulse, defaults: step_x rises 2 cycles after ax rises, high 4, low 4; pos_x=1; dir_x stays 1; done pulses once after start falls.
REQ-035 fax after reset: dir_x=0 at pop edge, step_x rises 2 cycles later; pos_x=-1.
REQ-036 ax every 3 cycles x10 with PULSE_W=4: queue fills, ovf=1, emitted steps = 10 minus drops, pos_x equals emitted count.
REQ-037 ax and fax rise same cycle: err=1, no step_x, pos_x unchanged; concurrent ay still produces a step.
REQ-038 ax held high 20 cycles: exactly one step.
REQ-039 Reset asserted during HIGH: step_x=0 and pos_x=0 immediately; after release, new ay gives pos_y=1.
